// File: rtl/gemm_pkg.sv
// gemm_pkg: shared definitions for the GEMM sequencer.
//   - datapath widths and the GEMM opcode
//   - instruction field positions, the decoded instruction struct and its decoder
//   - micro-op field positions
//   - sequencer FSM state enum
package gemm_pkg;

    localparam int INS_WIDTH     = 128;
    localparam int UPC_WIDTH     = 13;
    localparam int CNT_WIDTH     = 14;
    localparam int ACC_IDX_WIDTH = 11;
    localparam int INP_IDX_WIDTH = 11;
    localparam int WGT_IDX_WIDTH = 10;

    localparam logic [2:0] OPCODE_GEMM = 3'd2;

    // Instruction field positions
    localparam int OP_LSB        = 0;
    localparam int OP_MSB        = 2;
    localparam int POP_PREV_BIT  = 3;
    localparam int POP_NEXT_BIT  = 4;
    localparam int PUSH_PREV_BIT = 5;
    localparam int PUSH_NEXT_BIT = 6;
    localparam int RESET_BIT     = 7;
    localparam int UOP_BGN_LSB   = 8;
    localparam int UOP_BGN_MSB   = 20;
    localparam int UOP_END_LSB   = 21;
    localparam int UOP_END_MSB   = 34;
    localparam int ITER_OUT_LSB  = 35;
    localparam int ITER_OUT_MSB  = 48;
    localparam int ITER_IN_LSB   = 49;
    localparam int ITER_IN_MSB   = 62;
    localparam int DST_OUT_LSB   = 63;
    localparam int DST_OUT_MSB   = 73;
    localparam int DST_IN_LSB    = 74;
    localparam int DST_IN_MSB    = 84;
    localparam int SRC_OUT_LSB   = 85;
    localparam int SRC_OUT_MSB   = 95;
    localparam int SRC_IN_LSB    = 96;
    localparam int SRC_IN_MSB    = 106;
    localparam int WGT_OUT_LSB   = 107;
    localparam int WGT_OUT_MSB   = 116;
    localparam int WGT_IN_LSB    = 117;
    localparam int WGT_IN_MSB    = 126;

    // Micro-op field positions
    localparam int UOP_ACC_LSB = 0;
    localparam int UOP_ACC_MSB = 10;
    localparam int UOP_INP_LSB = 11;
    localparam int UOP_INP_MSB = 21;
    localparam int UOP_WGT_LSB = 22;
    localparam int UOP_WGT_MSB = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_EXEC,
        ST_DRAIN,
        ST_PUSH
    } state_e;

    typedef struct packed {
        logic [2:0]               opcode;
        logic                     pop_prev;
        logic                     pop_next;
        logic                     push_prev;
        logic                     push_next;
        logic                     reset_reg;
        logic [UPC_WIDTH-1:0]     uop_bgn;
        logic [CNT_WIDTH-1:0]     uop_end;
        logic [CNT_WIDTH-1:0]     iter_out;
        logic [CNT_WIDTH-1:0]     iter_in;
        logic [ACC_IDX_WIDTH-1:0] dst_out;
        logic [ACC_IDX_WIDTH-1:0] dst_in;
        logic [INP_IDX_WIDTH-1:0] src_out;
        logic [INP_IDX_WIDTH-1:0] src_in;
        logic [WGT_IDX_WIDTH-1:0] wgt_out;
        logic [WGT_IDX_WIDTH-1:0] wgt_in;
    } insn_t;

    function automatic insn_t decode_insn(input logic [INS_WIDTH-2:0] raw);
        insn_t d;
        d.opcode    = raw[OP_MSB:OP_LSB];
        d.pop_prev  = raw[POP_PREV_BIT];
        d.pop_next  = raw[POP_NEXT_BIT];
        d.push_prev = raw[PUSH_PREV_BIT];
        d.push_next = raw[PUSH_NEXT_BIT];
        d.reset_reg = raw[RESET_BIT];
        d.uop_bgn   = raw[UOP_BGN_MSB:UOP_BGN_LSB];
        d.uop_end   = raw[UOP_END_MSB:UOP_END_LSB];
        d.iter_out  = raw[ITER_OUT_MSB:ITER_OUT_LSB];
        d.iter_in   = raw[ITER_IN_MSB:ITER_IN_LSB];
        d.dst_out   = raw[DST_OUT_MSB:DST_OUT_LSB];
        d.dst_in    = raw[DST_IN_MSB:DST_IN_LSB];
        d.src_out   = raw[SRC_OUT_MSB:SRC_OUT_LSB];
        d.src_in    = raw[SRC_IN_MSB:SRC_IN_LSB];
        d.wgt_out   = raw[WGT_OUT_MSB:WGT_OUT_LSB];
        d.wgt_in    = raw[WGT_IN_MSB:WGT_IN_LSB];
        return d;
    endfunction

endpackage

// File: rtl/gemm_loop_gen.sv
// gemm_loop_gen: three-level loop counter for the GEMM sequencer.
//   start          : reload upc with uop_bgn, clear iteration counters and offsets
//   step           : advance one micro-op (upc innermost, then iter_in, then iter_out)
//   uop_bgn/uop_end, iter_in/iter_out : loop bounds (upc runs bgn..end-1)
//   *_factor_out/in: per-index offset increments for outer/inner iterations
//   upc, *_off_out/in : current micro-op address and offset accumulators
//   last           : current step is the final micro-op of the whole loop nest
module gemm_loop_gen
    import gemm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    input  logic [UPC_WIDTH-1:0]     uop_bgn,
    input  logic [CNT_WIDTH-1:0]     uop_end,
    input  logic [CNT_WIDTH-1:0]     iter_in,
    input  logic [CNT_WIDTH-1:0]     iter_out,
    input  logic [ACC_IDX_WIDTH-1:0] acc_factor_out,
    input  logic [ACC_IDX_WIDTH-1:0] acc_factor_in,
    input  logic [INP_IDX_WIDTH-1:0] inp_factor_out,
    input  logic [INP_IDX_WIDTH-1:0] inp_factor_in,
    input  logic [WGT_IDX_WIDTH-1:0] wgt_factor_out,
    input  logic [WGT_IDX_WIDTH-1:0] wgt_factor_in,
    output logic [CNT_WIDTH-1:0]     upc,
    output logic [ACC_IDX_WIDTH-1:0] acc_off_out,
    output logic [ACC_IDX_WIDTH-1:0] acc_off_in,
    output logic [INP_IDX_WIDTH-1:0] inp_off_out,
    output logic [INP_IDX_WIDTH-1:0] inp_off_in,
    output logic [WGT_IDX_WIDTH-1:0] wgt_off_out,
    output logic [WGT_IDX_WIDTH-1:0] wgt_off_in,
    output logic                     last
);

    logic [CNT_WIDTH-1:0]     upc_q, upc_d, in_q, in_d, out_q, out_d;
    logic [ACC_IDX_WIDTH-1:0] acc_out_q, acc_out_d, acc_in_q, acc_in_d;
    logic [INP_IDX_WIDTH-1:0] inp_out_q, inp_out_d, inp_in_q, inp_in_d;
    logic [WGT_IDX_WIDTH-1:0] wgt_out_q, wgt_out_d, wgt_in_q, wgt_in_d;
    logic [CNT_WIDTH-1:0]     upc_last, in_last, out_last;
    logic                     upc_wrap, in_wrap;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        upc_d     = upc_q;
        in_d      = in_q;
        out_d     = out_q;
        acc_out_d = acc_out_q;
        acc_in_d  = acc_in_q;
        inp_out_d = inp_out_q;
        inp_in_d  = inp_in_q;
        wgt_out_d = wgt_out_q;
        wgt_in_d  = wgt_in_q;

        upc_last = uop_end - CNT_WIDTH'(1);
        in_last  = iter_in - CNT_WIDTH'(1);
        out_last = iter_out - CNT_WIDTH'(1);
        upc_wrap = (upc_q == upc_last);
        in_wrap  = (in_q == in_last);
        last     = upc_wrap && in_wrap && (out_q == out_last);

        if (start) begin
            upc_d     = {1'b0, uop_bgn};
            in_d      = '0;
            out_d     = '0;
            acc_out_d = '0;
            acc_in_d  = '0;
            inp_out_d = '0;
            inp_in_d  = '0;
            wgt_out_d = '0;
            wgt_in_d  = '0;
        end else if (step) begin
            if (!upc_wrap) begin
                upc_d = upc_q + CNT_WIDTH'(1);
            end else begin
                upc_d = {1'b0, uop_bgn};
                if (in_wrap) begin
                    // Inner loop done: restart inner offsets, advance outer ones.
                    in_d      = '0;
                    out_d     = out_q + CNT_WIDTH'(1);
                    acc_in_d  = '0;
                    inp_in_d  = '0;
                    wgt_in_d  = '0;
                    acc_out_d = acc_out_q + acc_factor_out;
                    inp_out_d = inp_out_q + inp_factor_out;
                    wgt_out_d = wgt_out_q + wgt_factor_out;
                end else begin
                    in_d     = in_q + CNT_WIDTH'(1);
                    acc_in_d = acc_in_q + acc_factor_in;
                    inp_in_d = inp_in_q + inp_factor_in;
                    wgt_in_d = wgt_in_q + wgt_factor_in;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q     <= '0;
            in_q      <= '0;
            out_q     <= '0;
            acc_out_q <= '0;
            acc_in_q  <= '0;
            inp_out_q <= '0;
            inp_in_q  <= '0;
            wgt_out_q <= '0;
            wgt_in_q  <= '0;
        end else begin
            upc_q     <= upc_d;
            in_q      <= in_d;
            out_q     <= out_d;
            acc_out_q <= acc_out_d;
            acc_in_q  <= acc_in_d;
            inp_out_q <= inp_out_d;
            inp_in_q  <= inp_in_d;
            wgt_out_q <= wgt_out_d;
            wgt_in_q  <= wgt_in_d;
        end
    end

    assign upc         = upc_q;
    assign acc_off_out = acc_out_q;
    assign acc_off_in  = acc_in_q;
    assign inp_off_out = inp_out_q;
    assign inp_off_in  = inp_in_q;
    assign wgt_off_out = wgt_out_q;
    assign wgt_off_in  = wgt_in_q;

endmodule

// File: rtl/gemm_ctrl.sv
// gemm_ctrl: GEMM core sequencer.
//   insn_valid/insn_ready/insn         : 128-bit instruction handshake
//   l2g_/s2g_dep_valid/ready           : dependency tokens popped before execution
//   g2l_/g2s_dep_valid/ready           : dependency tokens pushed after execution
//   uop_rd_en/uop_rd_addr/uop_rd_data  : uop buffer read port (data one cycle later)
//   gemm_valid/gemm_reset, acc/inp/wgt_idx : index triple to the GEMM datapath
//   busy, done                         : instruction in flight; completion pulse
module gemm_ctrl
    import gemm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     insn_valid,
    output logic                     insn_ready,
    input  logic [INS_WIDTH-1:0]     insn,
    input  logic                     l2g_dep_valid,
    output logic                     l2g_dep_ready,
    input  logic                     s2g_dep_valid,
    output logic                     s2g_dep_ready,
    output logic                     g2l_dep_valid,
    input  logic                     g2l_dep_ready,
    output logic                     g2s_dep_valid,
    input  logic                     g2s_dep_ready,
    output logic                     uop_rd_en,
    output logic [UPC_WIDTH-1:0]     uop_rd_addr,
    input  logic [31:0]              uop_rd_data,
    output logic                     gemm_valid,
    output logic                     gemm_reset,
    output logic [ACC_IDX_WIDTH-1:0] acc_idx,
    output logic [INP_IDX_WIDTH-1:0] inp_idx,
    output logic [WGT_IDX_WIDTH-1:0] wgt_idx,
    output logic                     busy,
    output logic                     done
);

    state_e                   state_q, state_d;
    insn_t                    insn_q, insn_d;
    logic [1:0]               pop_owed_q, pop_owed_d;    // {next, prev}
    logic [1:0]               push_owed_q, push_owed_d;  // {next, prev}
    logic                     valid_q, valid_d;
    logic [ACC_IDX_WIDTH-1:0] acc_off_q, acc_off_d;
    logic [INP_IDX_WIDTH-1:0] inp_off_q, inp_off_d;
    logic [WGT_IDX_WIDTH-1:0] wgt_off_q, wgt_off_d;

    logic                     loop_start, loop_step, loop_last, empty;
    logic [CNT_WIDTH-1:0]     upc;
    logic [ACC_IDX_WIDTH-1:0] acc_off_out, acc_off_in;
    logic [INP_IDX_WIDTH-1:0] inp_off_out, inp_off_in;
    logic [WGT_IDX_WIDTH-1:0] wgt_off_out, wgt_off_in;
    logic                     unused_bits;

    gemm_loop_gen u_loop (
        .clk            (clk),
        .rst            (rst),
        .start          (loop_start),
        .step           (loop_step),
        .uop_bgn        (insn_q.uop_bgn),
        .uop_end        (insn_q.uop_end),
        .iter_in        (insn_q.iter_in),
        .iter_out       (insn_q.iter_out),
        .acc_factor_out (insn_q.dst_out),
        .acc_factor_in  (insn_q.dst_in),
        .inp_factor_out (insn_q.src_out),
        .inp_factor_in  (insn_q.src_in),
        .wgt_factor_out (insn_q.wgt_out),
        .wgt_factor_in  (insn_q.wgt_in),
        .upc            (upc),
        .acc_off_out    (acc_off_out),
        .acc_off_in     (acc_off_in),
        .inp_off_out    (inp_off_out),
        .inp_off_in     (inp_off_in),
        .wgt_off_out    (wgt_off_out),
        .wgt_off_in     (wgt_off_in),
        .last           (loop_last)
    );

    assign empty = (insn_q.opcode != OPCODE_GEMM) || (insn_q.iter_out == '0) ||
                   (insn_q.iter_in == '0) || (insn_q.uop_end <= {1'b0, insn_q.uop_bgn});

    always_comb begin
        state_d       = state_q;
        insn_d        = insn_q;
        pop_owed_d    = pop_owed_q;
        push_owed_d   = push_owed_q;
        insn_ready    = 1'b0;
        l2g_dep_ready = 1'b0;
        s2g_dep_ready = 1'b0;
        g2l_dep_valid = 1'b0;
        g2s_dep_valid = 1'b0;
        uop_rd_en     = 1'b0;
        done          = 1'b0;
        loop_start    = 1'b0;
        loop_step     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                insn_ready = 1'b1;
                if (insn_valid) begin
                    insn_d      = decode_insn(insn[INS_WIDTH-2:0]);
                    pop_owed_d  = {insn[POP_NEXT_BIT], insn[POP_PREV_BIT]};
                    push_owed_d = {insn[PUSH_NEXT_BIT], insn[PUSH_PREV_BIT]};
                    state_d     = ST_POP;
                end
            end
            ST_POP: begin
                // Counters are held at their start values while tokens are awaited.
                loop_start    = 1'b1;
                l2g_dep_ready = pop_owed_q[0];
                s2g_dep_ready = pop_owed_q[1];
                if (l2g_dep_valid) pop_owed_d[0] = 1'b0;
                if (s2g_dep_valid) pop_owed_d[1] = 1'b0;
                if (pop_owed_d == 2'b00) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (empty) begin
                    state_d = ST_PUSH;
                end else begin
                    uop_rd_en = 1'b1;
                    loop_step = 1'b1;
                    if (loop_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                g2l_dep_valid = push_owed_q[0];
                g2s_dep_valid = push_owed_q[1];
                if (g2l_dep_ready) push_owed_d[0] = 1'b0;
                if (g2s_dep_ready) push_owed_d[1] = 1'b0;
                if (push_owed_q == 2'b00) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Offsets travel one stage alongside the read so they line up with its data.
        valid_d   = uop_rd_en;
        acc_off_d = acc_off_out + acc_off_in;
        inp_off_d = inp_off_out + inp_off_in;
        wgt_off_d = wgt_off_out + wgt_off_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            insn_q      <= '0;
            pop_owed_q  <= '0;
            push_owed_q <= '0;
            valid_q     <= 1'b0;
            acc_off_q   <= '0;
            inp_off_q   <= '0;
            wgt_off_q   <= '0;
        end else begin
            state_q     <= state_d;
            insn_q      <= insn_d;
            pop_owed_q  <= pop_owed_d;
            push_owed_q <= push_owed_d;
            valid_q     <= valid_d;
            acc_off_q   <= acc_off_d;
            inp_off_q   <= inp_off_d;
            wgt_off_q   <= wgt_off_d;
        end
    end

    always_comb begin
        acc_idx = '0;
        inp_idx = '0;
        wgt_idx = '0;
        if (valid_q) begin
            acc_idx = uop_rd_data[UOP_ACC_MSB:UOP_ACC_LSB] + acc_off_q;
            inp_idx = uop_rd_data[UOP_INP_MSB:UOP_INP_LSB] + inp_off_q;
            wgt_idx = uop_rd_data[UOP_WGT_MSB:UOP_WGT_LSB] + wgt_off_q;
        end
    end

    assign gemm_valid  = valid_q;
    assign gemm_reset  = valid_q & insn_q.reset_reg;
    assign uop_rd_addr = upc[UPC_WIDTH-1:0];
    assign busy        = (state_q != ST_IDLE);
    assign unused_bits = ^{insn[INS_WIDTH-1], upc[CNT_WIDTH-1]};

endmodule
